// File: rtl/iic_recv.sv
// I2C target receiver: filters SCL/SDA, detects START/STOP, ACKs write frames to its own address
// and strobes each data byte out with an auto-incrementing register pointer.
`timescale 1ns/1ps
module iic_recv #(
    parameter int unsigned FILTER_LEN = 3
) (
    input  logic       sys_clk,
    input  logic       sys_reset,
    input  logic [6:0] iic_device_addr,
    input  logic       iic_scl,
    inout  wire        iic_sda,
    output logic [7:0] iic_recv_addr,
    output logic [7:0] iic_recv_data,
    output logic       iic_recv_valid,
    output logic       iic_busy,
    output logic       iic_frame_done
);

    typedef enum logic [2:0] {
        StIdle, StDev, StAckDev, StReg, StAckReg, StData, StAckData, StIgnore
    } state_e;

    // Index 0 is SCL, index 1 is SDA throughout the input path.
    logic [1:0]      sync1_q, sync2_q, filt_q, filt_d, prev_q;
    logic [1:0][3:0] cnt_q, cnt_d;

    state_e      state_q, state_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  ptr_q, ptr_d;
    logic        oe_q, oe_d;
    logic        ack_ph_q, ack_ph_d;
    logic        acked_q, acked_d;
    logic        valid_q, valid_d;
    logic        done_q, done_d;
    logic [7:0]  addr_q, addr_d;
    logic [7:0]  data_q, data_d;

    logic       scl_rise, scl_fall, start_det, stop_det;
    logic [7:0] byte_nxt;

    always_comb begin
        filt_d = filt_q;
        cnt_d  = '0;
        for (int i = 0; i < 2; i++) begin
            if (sync2_q[i] != filt_q[i]) begin
                if (cnt_q[i] == 4'(FILTER_LEN - 1)) begin
                    filt_d[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 4'd1;
                end
            end
        end
    end

    assign scl_rise  = filt_q[0] & ~prev_q[0];
    assign scl_fall  = ~filt_q[0] & prev_q[0];
    assign start_det = prev_q[1] & ~filt_q[1] & filt_q[0];
    assign stop_det  = ~prev_q[1] & filt_q[1] & filt_q[0];
    assign byte_nxt  = {shift_q[6:0], filt_q[1]};

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        ptr_d     = ptr_q;
        oe_d      = oe_q;
        ack_ph_d  = ack_ph_q;
        acked_d   = acked_q;
        valid_d   = 1'b0;
        done_d    = 1'b0;
        addr_d    = addr_q;
        data_d    = data_q;

        if (start_det) begin
            state_d   = StDev;
            bit_cnt_d = '0;
            oe_d      = 1'b0;
            ack_ph_d  = 1'b0;
            acked_d   = 1'b0;
        end else if (stop_det) begin
            state_d   = StIdle;
            bit_cnt_d = '0;
            oe_d      = 1'b0;
            ack_ph_d  = 1'b0;
            done_d    = acked_q;
            acked_d   = 1'b0;
        end else begin
            unique case (state_q)
                StIdle, StIgnore: ;
                StDev, StReg, StData: begin
                    if (scl_rise) begin
                        shift_d   = byte_nxt;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            unique case (state_q)
                                StDev: begin
                                    if (byte_nxt[7:1] == iic_device_addr && !byte_nxt[0]) begin
                                        state_d = StAckDev;
                                        acked_d = 1'b1;
                                    end else begin
                                        state_d = StIgnore;
                                    end
                                end
                                StReg: begin
                                    ptr_d   = byte_nxt;
                                    state_d = StAckReg;
                                end
                                default: begin
                                    valid_d = 1'b1;
                                    data_d  = byte_nxt;
                                    addr_d  = ptr_q;
                                    state_d = StAckData;
                                end
                            endcase
                        end
                    end
                end
                StAckDev, StAckReg, StAckData: begin
                    // First fall after the byte drives ACK, second fall ends the ACK clock.
                    if (scl_fall) begin
                        if (!ack_ph_q) begin
                            oe_d     = 1'b1;
                            ack_ph_d = 1'b1;
                        end else begin
                            oe_d     = 1'b0;
                            ack_ph_d = 1'b0;
                            unique case (state_q)
                                StAckDev: state_d = StReg;
                                StAckReg: state_d = StData;
                                default: begin
                                    state_d = StData;
                                    ptr_d   = ptr_q + 8'd1;
                                end
                            endcase
                        end
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge sys_clk or posedge sys_reset) begin
        if (sys_reset) begin
            sync1_q   <= 2'b11;
            sync2_q   <= 2'b11;
            filt_q    <= 2'b11;
            prev_q    <= 2'b11;
            cnt_q     <= '0;
            state_q   <= StIdle;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            ptr_q     <= '0;
            oe_q      <= 1'b0;
            ack_ph_q  <= 1'b0;
            acked_q   <= 1'b0;
            valid_q   <= 1'b0;
            done_q    <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
        end else begin
            sync1_q   <= {iic_sda, iic_scl};
            sync2_q   <= sync1_q;
            filt_q    <= filt_d;
            prev_q    <= filt_q;
            cnt_q     <= cnt_d;
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            ptr_q     <= ptr_d;
            oe_q      <= oe_d;
            ack_ph_q  <= ack_ph_d;
            acked_q   <= acked_d;
            valid_q   <= valid_d;
            done_q    <= done_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
        end
    end

    assign iic_sda        = oe_q ? 1'b0 : 1'bz;
    assign iic_recv_addr  = addr_q;
    assign iic_recv_data  = data_q;
    assign iic_recv_valid = valid_q;
    assign iic_frame_done = done_q;
    assign iic_busy       = (state_q != StIdle);

endmodule

// File: tb/tb_iic_recv.sv
// Directed bench for iic_recv: an open-drain bus master drives frames, a monitor logs strobes.
`timescale 1ns/1ps
module tb_iic_recv;
    localparam int Q = 10;

    logic       sys_clk = 1'b0;
    logic       sys_reset = 1'b1;
    logic [6:0] dev_addr = 7'h3C;
    logic       m_scl = 1'b1;
    logic       m_sda = 1'b1;
    wire        sda;
    logic [7:0] recv_addr, recv_data;
    logic       recv_valid, busy, frame_done;

    pullup (sda);
    assign sda = m_sda ? 1'bz : 1'b0;

    iic_recv #(.FILTER_LEN(3)) dut (
        .sys_clk        (sys_clk),
        .sys_reset      (sys_reset),
        .iic_device_addr(dev_addr),
        .iic_scl        (m_scl),
        .iic_sda        (sda),
        .iic_recv_addr  (recv_addr),
        .iic_recv_data  (recv_data),
        .iic_recv_valid (recv_valid),
        .iic_busy       (busy),
        .iic_frame_done (frame_done)
    );

    always #5 sys_clk = ~sys_clk;

    int vecs = 0;
    int errs = 0;
    int st_n = 0;
    int fd_n = 0;
    logic [7:0] st_addr [64];
    logic [7:0] st_data [64];

    always @(negedge sys_clk) begin
        if (recv_valid && st_n < 64) begin
            st_addr[st_n] = recv_addr;
            st_data[st_n] = recv_data;
            st_n++;
        end
        if (frame_done) fd_n++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    task automatic send_bit(input logic b, input logic glitch);
        m_sda = b;
        if (glitch) begin
            tick(4);
            m_scl = 1'b1;
            tick(1);
            m_scl = 1'b0;
            tick(Q - 5);
        end else begin
            tick(Q);
        end
        m_scl = 1'b1;
        tick(2 * Q);
        m_scl = 1'b0;
        tick(Q);
    endtask

    task automatic ack_slot(output logic ack);
        m_sda = 1'b1;
        tick(Q);
        m_scl = 1'b1;
        tick(Q);
        ack = (sda === 1'b0);
        tick(Q);
        m_scl = 1'b0;
        tick(Q);
    endtask

    task automatic send_byte(input logic [7:0] b, input int glitch_at, output logic ack);
        for (int i = 7; i >= 0; i--) send_bit(b[i], i == glitch_at);
        ack_slot(ack);
    endtask

    task automatic start_c();
        m_sda = 1'b1;
        tick(Q);
        m_scl = 1'b1;
        tick(Q);
        m_sda = 1'b0;
        tick(Q);
        m_scl = 1'b0;
        tick(Q);
    endtask

    task automatic stop_c();
        m_sda = 1'b0;
        tick(Q);
        m_scl = 1'b1;
        tick(Q);
        m_sda = 1'b1;
        tick(2 * Q);
    endtask

    initial begin
        logic ack;
        int   b0, f0;
        logic [7:0] v;

        tick(3);
        chk("rst_sda", {31'd0, sda}, 32'd1);
        chk("rst_valid", {31'd0, recv_valid}, 32'd0);
        chk("rst_addr", {24'd0, recv_addr}, 32'h00);
        chk("rst_data", {24'd0, recv_data}, 32'h00);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, frame_done}, 32'd0);
        sys_reset = 1'b0;
        tick(20);

        // Single-byte frame
        b0 = st_n; f0 = fd_n;
        start_c();
        send_byte(8'h78, -1, ack); chk("t1_ack_dev", {31'd0, ack}, 32'd1);
        send_byte(8'h10, -1, ack); chk("t1_ack_reg", {31'd0, ack}, 32'd1);
        send_byte(8'hA5, -1, ack); chk("t1_ack_dat", {31'd0, ack}, 32'd1);
        chk("t1_busy_mid", {31'd0, busy}, 32'd1);
        stop_c();
        tick(10);
        chk("t1_count", st_n - b0, 32'd1);
        chk("t1_addr", {24'd0, st_addr[b0]}, 32'h10);
        chk("t1_data", {24'd0, st_data[b0]}, 32'hA5);
        chk("t1_done", fd_n - f0, 32'd1);
        chk("t1_busy_end", {31'd0, busy}, 32'd0);
        chk("t1_hold_data", {24'd0, recv_data}, 32'hA5);

        // Burst with pointer wrap
        b0 = st_n;
        start_c();
        send_byte(8'h78, -1, ack); chk("t2_ack_dev", {31'd0, ack}, 32'd1);
        send_byte(8'hFE, -1, ack); chk("t2_ack_reg", {31'd0, ack}, 32'd1);
        send_byte(8'h11, -1, ack); chk("t2_ack_d0", {31'd0, ack}, 32'd1);
        send_byte(8'h22, -1, ack); chk("t2_ack_d1", {31'd0, ack}, 32'd1);
        send_byte(8'h33, -1, ack); chk("t2_ack_d2", {31'd0, ack}, 32'd1);
        stop_c();
        tick(10);
        chk("t2_count", st_n - b0, 32'd3);
        chk("t2_a0", {24'd0, st_addr[b0]}, 32'hFE);
        chk("t2_d0", {24'd0, st_data[b0]}, 32'h11);
        chk("t2_a1", {24'd0, st_addr[b0+1]}, 32'hFF);
        chk("t2_d1", {24'd0, st_data[b0+1]}, 32'h22);
        chk("t2_a2", {24'd0, st_addr[b0+2]}, 32'h00);
        chk("t2_d2", {24'd0, st_data[b0+2]}, 32'h33);

        // Foreign address, then read request
        b0 = st_n; f0 = fd_n;
        start_c();
        send_byte(8'h7A, -1, ack); chk("t3_nack_addr", {31'd0, ack}, 32'd0);
        send_byte(8'h10, -1, ack); chk("t3_nack_b1", {31'd0, ack}, 32'd0);
        chk("t3_busy_ign", {31'd0, busy}, 32'd1);
        stop_c();
        tick(10);
        chk("t3_busy_end", {31'd0, busy}, 32'd0);
        start_c();
        send_byte(8'h79, -1, ack); chk("t3_nack_rd", {31'd0, ack}, 32'd0);
        send_byte(8'h10, -1, ack); chk("t3_nack_b2", {31'd0, ack}, 32'd0);
        stop_c();
        tick(10);
        chk("t3_busy_end2", {31'd0, busy}, 32'd0);
        chk("t3_count", st_n - b0, 32'd0);
        chk("t3_done", fd_n - f0, 32'd0);

        // Repeated START mid-byte drops the partial byte
        b0 = st_n; f0 = fd_n;
        start_c();
        send_byte(8'h78, -1, ack);
        send_byte(8'h30, -1, ack); chk("t4_ack_reg", {31'd0, ack}, 32'd1);
        v = 8'hA0;
        for (int i = 7; i >= 4; i--) send_bit(v[i], 1'b0);
        start_c();
        send_byte(8'h78, -1, ack); chk("t4_ack_dev2", {31'd0, ack}, 32'd1);
        send_byte(8'h20, -1, ack);
        send_byte(8'h55, -1, ack); chk("t4_ack_dat", {31'd0, ack}, 32'd1);
        stop_c();
        tick(10);
        chk("t4_count", st_n - b0, 32'd1);
        chk("t4_addr", {24'd0, st_addr[b0]}, 32'h20);
        chk("t4_data", {24'd0, st_data[b0]}, 32'h55);
        chk("t4_done", fd_n - f0, 32'd1);

        // Single-cycle SCL glitch inside a data bit
        b0 = st_n;
        start_c();
        send_byte(8'h78, -1, ack);
        send_byte(8'h40, -1, ack);
        send_byte(8'h96, 2, ack); chk("t5_ack", {31'd0, ack}, 32'd1);
        stop_c();
        tick(10);
        chk("t5_count", st_n - b0, 32'd1);
        chk("t5_addr", {24'd0, st_addr[b0]}, 32'h40);
        chk("t5_data", {24'd0, st_data[b0]}, 32'h96);

        // Reset while the target holds SDA low in a data ACK
        b0 = st_n; f0 = fd_n;
        start_c();
        send_byte(8'h78, -1, ack);
        send_byte(8'h50, -1, ack);
        v = 8'hC3;
        for (int i = 7; i >= 0; i--) send_bit(v[i], 1'b0);
        m_sda = 1'b1;
        tick(Q / 2);
        chk("t6_sda_low", {31'd0, sda}, 32'd0);
        chk("t6_pre_data", {24'd0, recv_data}, 32'hC3);
        sys_reset = 1'b1;
        #1;
        chk("t6_sda_rel", {31'd0, sda}, 32'd1);
        chk("t6_valid", {31'd0, recv_valid}, 32'd0);
        chk("t6_addr", {24'd0, recv_addr}, 32'h00);
        chk("t6_data", {24'd0, recv_data}, 32'h00);
        chk("t6_busy", {31'd0, busy}, 32'd0);
        chk("t6_done", {31'd0, frame_done}, 32'd0);
        tick(2);
        sys_reset = 1'b0;
        tick(Q / 2);
        m_scl = 1'b1;
        tick(2 * Q);
        m_scl = 1'b0;
        tick(Q);
        send_byte(8'h12, -1, ack); chk("t6_ignored", {31'd0, ack}, 32'd0);
        chk("t6_idle", {31'd0, busy}, 32'd0);
        stop_c();
        tick(10);
        chk("t6_count_a", st_n - b0, 32'd1);
        chk("t6_done_a", fd_n - f0, 32'd0);
        start_c();
        send_byte(8'h78, -1, ack); chk("t6_ack_dev", {31'd0, ack}, 32'd1);
        send_byte(8'h60, -1, ack);
        send_byte(8'h34, -1, ack); chk("t6_ack_dat", {31'd0, ack}, 32'd1);
        stop_c();
        tick(10);
        chk("t6_count_b", st_n - b0, 32'd2);
        chk("t6_addr_b", {24'd0, st_addr[b0+1]}, 32'h60);
        chk("t6_data_b", {24'd0, st_data[b0+1]}, 32'h34);
        chk("t6_done_b", fd_n - f0, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
